// File: rtl/exc_controller.sv
// exc_controller: exception/interrupt entry controller.
//
// Latches rising edges of four external interrupt lines into a pending
// register, arbitrates them against the invalid-opcode condition, and runs a
// request/acknowledge handshake with the datapath. Entering a handler is
// tracked so a second invalid opcode inside the handler escalates to a
// terminal double-fault state that only reset leaves.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   reset       in   synchronous, active-high reset
//   ExtIRQ      in   [3:0] interrupt lines (level, rising-edge triggered)
//   IrqEnable   in   [3:0] per-line delivery enable
//   NotAnInstr  in   invalid opcode in the current instruction
//   ExcAck      in   datapath acknowledge of exception entry
//   ERet        in   ERET instruction executing
//   Exc         out  registered exception request
//   EStatus     out  [3:0] registered cause code
//   InHandler   out  high in HANDLER or FAULT
//   IrqPending  out  [3:0] pending register
module exc_controller #(
  parameter logic [3:0] IRQ_BASE   = 4'b0010,
  parameter logic [3:0] FAULT_CODE = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ExtIRQ,
  input  logic [3:0] IrqEnable,
  input  logic       NotAnInstr,
  input  logic       ExcAck,
  input  logic       ERet,
  output logic       Exc,
  output logic [3:0] EStatus,
  output logic       InHandler,
  output logic [3:0] IrqPending
);

  localparam logic [3:0] INSTR_CODE = 4'b0001;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER, FAULT} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] prev_q;
  logic       exc_q, exc_d;
  logic [3:0] estatus_q, estatus_d;
  logic [1:0] src_q, src_d;          // index of the delivered interrupt line
  logic       src_irq_q, src_irq_d;  // 0 when the delivered cause was an invalid opcode

  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] avail;
  logic [1:0] sel_idx;
  logic       sel_any;

  assign rise  = ExtIRQ & ~prev_q;
  // Arbitration looks at the pending value before this edge's new edges.
  assign avail = pending_q & IrqEnable;

  // Lowest-numbered available line wins: scan downward so the last hit sticks.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (avail[i]) begin
        sel_any = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    estatus_d = estatus_q;
    src_d     = src_q;
    src_irq_d = src_irq_q;
    clr       = 4'b0000;

    unique case (state_q)
      IDLE: begin
        exc_d = 1'b0;
        if (NotAnInstr) begin
          exc_d     = 1'b1;
          estatus_d = INSTR_CODE;
          src_irq_d = 1'b0;
          state_d   = REQ;
        end else if (sel_any) begin
          exc_d     = 1'b1;
          estatus_d = IRQ_BASE + {2'b00, sel_idx};
          src_d     = sel_idx;
          src_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (ExcAck) begin
          exc_d   = 1'b0;
          state_d = HANDLER;
          if (src_irq_q) clr[src_q] = 1'b1;
        end
      end
      HANDLER: begin
        exc_d = 1'b0;
        // An invalid opcode inside the handler outranks a simultaneous ERET.
        if (NotAnInstr) begin
          exc_d     = 1'b1;
          estatus_d = FAULT_CODE;
          state_d   = FAULT;
        end else if (ERet) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        exc_d     = 1'b1;
        estatus_d = FAULT_CODE;
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the line being cleared keeps the bit set.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    // Edge history keeps tracking through reset so held-high lines stay quiet.
    prev_q <= ExtIRQ;
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      exc_q     <= 1'b0;
      estatus_q <= 4'b0000;
      src_q     <= 2'd0;
      src_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      exc_q     <= exc_d;
      estatus_q <= estatus_d;
      src_q     <= src_d;
      src_irq_q <= src_irq_d;
    end
  end

  assign Exc        = exc_q;
  assign EStatus    = estatus_q;
  assign InHandler  = (state_q == HANDLER) || (state_q == FAULT);
  assign IrqPending = pending_q;

endmodule

// File: tb/tb_exc_controller.sv
// tb_exc_controller: directed scenarios for exc_controller. Each step drives
// one cycle of inputs, pushes the hand-derived expected outputs onto a
// scoreboard queue, and after the clock edge pops and compares them.
module tb_exc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ExtIRQ;
  logic [3:0] IrqEnable;
  logic       NotAnInstr;
  logic       ExcAck;
  logic       ERet;
  logic       Exc;
  logic [3:0] EStatus;
  logic       InHandler;
  logic [3:0] IrqPending;

  exc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .IrqEnable  (IrqEnable),
    .NotAnInstr (NotAnInstr),
    .ExcAck     (ExcAck),
    .ERet       (ERet),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .InHandler  (InHandler),
    .IrqPending (IrqPending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       exc;
    logic [3:0] est;
    logic [3:0] pend;
    logic       inh;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    else
      n_pass++;
  endtask

  // One clock: drive inputs, queue expectation, clock, compare.
  task automatic step(input string tag, input logic rst, input logic [3:0] ext,
                      input logic [3:0] en, input logic nai, input logic ack,
                      input logic eret, input logic e_exc, input logic [3:0] e_est,
                      input logic [3:0] e_pend, input logic e_inh);
    exp_t e;
    reset = rst; ExtIRQ = ext; IrqEnable = en;
    NotAnInstr = nai; ExcAck = ack; ERet = eret;
    e.tag = tag; e.exc = e_exc; e.est = e_est; e.pend = e_pend; e.inh = e_inh;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
    end else begin
      e = sb_q.pop_front();
      $display("step %-6s exc=%b est=%b pend=%b inh=%b", e.tag, Exc, EStatus, IrqPending, InHandler);
      check_eq({e.tag, ".exc"},  {3'b000, Exc},       {3'b000, e.exc});
      check_eq({e.tag, ".est"},  EStatus,             e.est);
      check_eq({e.tag, ".pend"}, IrqPending,          e.pend);
      check_eq({e.tag, ".inh"},  {3'b000, InHandler}, {3'b000, e.inh});
    end
  endtask

  initial begin
    reset = 1'b1; ExtIRQ = 4'h0; IrqEnable = 4'h0;
    NotAnInstr = 1'b0; ExcAck = 1'b0; ERet = 1'b0;

    // IRQ delivery; REQ ignores ERet/NotAnInstr; ack outside REQ is inert
    //        tag   rst ext      en       nai ack ret  exc est      pend     inh
    step("d0",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("d1",  0, 4'b0001, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0001, 0);
    step("d2",  0, 4'b0000, 4'b1111, 0, 0, 0,  1, 4'b0010, 4'b0001, 0);
    step("d3",  0, 4'b0000, 4'b1111, 1, 0, 1,  1, 4'b0010, 4'b0001, 0);
    step("d4",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0010, 4'b0000, 1);
    step("d5",  0, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0010, 4'b0000, 1);
    step("d6",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0010, 4'b0000, 0);
    step("d7",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0010, 4'b0000, 0);

    // Priority: invalid opcode first, then lowest enabled line
    step("p0",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("p1",  0, 4'b1100, 4'b1111, 1, 0, 0,  1, 4'b0001, 4'b1100, 0);
    step("p2",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0001, 4'b1100, 1);
    step("p3",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0001, 4'b1100, 0);
    step("p4",  0, 4'b0000, 4'b1111, 0, 0, 0,  1, 4'b0100, 4'b1100, 0);
    step("p5",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0100, 4'b1000, 1);
    step("p6",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0100, 4'b1000, 0);
    step("p7",  0, 4'b0000, 4'b1111, 0, 0, 0,  1, 4'b0101, 4'b1000, 0);
    step("p8",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0101, 4'b0000, 1);
    step("p9",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0101, 4'b0000, 0);

    // Masking: pending waits while disabled, delivered once enabled
    step("m0",  1, 4'b0000, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("m1",  0, 4'b0010, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0010, 0);
    for (int i = 0; i < 10; i++)
      step($sformatf("mw%0d", i), 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 0);
    step("m2",  0, 4'b0000, 4'b0010, 0, 0, 0,  1, 4'b0011, 4'b0010, 0);
    step("m3",  0, 4'b0000, 4'b0010, 0, 1, 0,  0, 4'b0011, 4'b0000, 1);
    step("m4",  0, 4'b0000, 4'b0010, 0, 0, 1,  0, 4'b0011, 4'b0000, 0);

    // Double fault is terminal until reset
    step("f0",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("f1",  0, 4'b0000, 4'b1111, 1, 0, 0,  1, 4'b0001, 4'b0000, 0);
    step("f2",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0001, 4'b0000, 1);
    step("f3",  0, 4'b0000, 4'b1111, 1, 0, 1,  1, 4'b1111, 4'b0000, 1);
    step("f4",  0, 4'b0000, 4'b1111, 0, 1, 0,  1, 4'b1111, 4'b0000, 1);
    step("f5",  0, 4'b0000, 4'b1111, 0, 0, 1,  1, 4'b1111, 4'b0000, 1);
    step("f6",  0, 4'b0000, 4'b1111, 0, 1, 1,  1, 4'b1111, 4'b0000, 1);
    step("f7",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);

    // Collision: new edge on the acked line keeps it pending
    step("c0",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("c1",  0, 4'b0001, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0001, 0);
    step("c2",  0, 4'b0000, 4'b1111, 0, 0, 0,  1, 4'b0010, 4'b0001, 0);
    step("c3",  0, 4'b0001, 4'b1111, 0, 1, 0,  0, 4'b0010, 4'b0001, 1);
    step("c4",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0010, 4'b0001, 0);
    step("c5",  0, 4'b0000, 4'b1111, 0, 0, 0,  1, 4'b0010, 4'b0001, 0);
    step("c6",  0, 4'b0000, 4'b1111, 0, 1, 0,  0, 4'b0010, 4'b0000, 1);
    step("c7",  0, 4'b0000, 4'b1111, 0, 0, 1,  0, 4'b0010, 4'b0000, 0);

    // Reset mid-REQ with the line held high: no re-trigger afterwards
    step("r0",  1, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("r1",  0, 4'b0001, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0001, 0);
    step("r2",  0, 4'b0001, 4'b1111, 0, 0, 0,  1, 4'b0010, 4'b0001, 0);
    step("r3",  1, 4'b0001, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("rh%0d", i), 0, 4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    step("r4",  0, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("r5",  0, 4'b0000, 4'b1111, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_controller.md
EXC_CONTROLLER -- requirements
Module: exc_controller

Interface
REQ-001 The block SHALL have parameter IRQ_BASE, default 4'b0010, which is the EStatus code for ExtIRQ[0]; ExtIRQ[i] SHALL use IRQ_BASE+i.
REQ-002 The block SHALL have parameter FAULT_CODE, default 4'b1111, which is the EStatus code for a double fault.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port ExtIRQ, input, 4 bits: external interrupt request lines, level signals, rising-edge triggered.
REQ-006 Port IrqEnable, input, 4 bits: per-line delivery enable.
REQ-007 Port NotAnInstr, input, 1 bit: decoder flag for an invalid opcode in the current instruction.
REQ-008 Port ExcAck, input, 1 bit: the datapath's acknowledge of exception entry.
REQ-009 Port ERet, input, 1 bit: an ERET instruction is executing.
REQ-010 Port Exc, output, 1 bit: exception request to the datapath; registered.
REQ-011 Port EStatus, output, 4 bits: cause code; registered.
REQ-012 Port InHandler, output, 1 bit: high when state is HANDLER or FAULT.
REQ-013 Port IrqPending, output, 4 bits: the pending register.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, HANDLER and FAULT.
REQ-015 A rising edge on ExtIRQ[i] SHALL set pending[i] at the same clock edge; a rising edge means ExtIRQ[i]=1 with the registered prev[i]=0.
REQ-016 prev SHALL register ExtIRQ every cycle.
REQ-017 The cause code SHALL be 4'b0001 if NotAnInstr=1; otherwise it SHALL be the lowest i with pending[i]&IrqEnable[i], giving IRQ_BASE+i.
REQ-018 The selection in REQ-017 SHALL use the pending register value before the current edge's update.
REQ-019 IDLE: if NotAnInstr=1 or (pending&IrqEnable)!=0, then at the next edge Exc SHALL go to 1, EStatus SHALL take the code, the index of the delivered source SHALL be latched, and the state SHALL become REQ.
REQ-020 IDLE with no request: Exc SHALL be 0 and EStatus SHALL hold its last value.
REQ-021 REQ: Exc and EStatus SHALL stay stable until ExcAck=1 is sampled.
REQ-022 REQ, on the edge where ExcAck=1 is sampled:
- Exc SHALL go to 0.
- The delivered pending bit SHALL clear (no clear for the invalid-opcode cause).
- The state SHALL become HANDLER.
REQ-023 REQ SHALL have no timeout, and NotAnInstr and ERet SHALL be ignored in REQ.
REQ-024 HANDLER: ERet=1 SHALL return the state to IDLE at the next edge.
REQ-025 Nesting is not allowed: pending interrupts SHALL wait in HANDLER.
REQ-026 HANDLER with NotAnInstr=1 SHALL go to FAULT, with Exc=1 and EStatus=FAULT_CODE at the next edge.
REQ-027 If NotAnInstr=1 and ERet=1 together in HANDLER, NotAnInstr SHALL win.
REQ-028 FAULT is terminal: Exc SHALL stay 1 and EStatus SHALL stay FAULT_CODE, and ExcAck and ERet SHALL be ignored until reset.
REQ-029 ExcAck outside REQ and ERet outside HANDLER SHALL have no effect.
REQ-030 A new edge on the same line as a delivered source in the ExcAck cycle: set SHALL win over clear, and pending[i] SHALL remain 1.
REQ-031 Pending bits with IrqEnable=0 SHALL remain set and SHALL be delivered once enabled; pending SHALL never clear without delivery.
REQ-032 After ERet, at least one IDLE cycle (Exc=0) SHALL occur before the next request.
REQ-033 Latency: an ExtIRQ edge sampled at edge t SHALL produce Exc=1 after edge t+1 when the block is IDLE and the line is enabled; NotAnInstr sampled at edge t SHALL produce Exc=1 after edge t.

Reset
REQ-034 While reset=1 at an edge, the block SHALL set: state IDLE, Exc=0, EStatus=4'b0000, pending=0, InHandler=0.
REQ-035 While reset=1, prev SHALL still load ExtIRQ, so a line held high across reset SHALL NOT create a pending bit.
REQ-036 Reset asserted in any state, including mid-handshake and FAULT, SHALL take effect at the next edge with no other state preserved.

Verification
REQ-037 IRQ delivery: after reset, pulse ExtIRQ=0001 with IrqEnable=1111 -> pending=0001 next cycle, then Exc=1 with EStatus=0010; ExcAck=1 -> Exc=0, pending=0000, InHandler=1; ERet=1 -> IDLE.
REQ-038 Priority: ExtIRQ=1100 and NotAnInstr=1 in the same cycle -> EStatus=0001 first; after ack and ERet -> EStatus=0100, then EStatus=0101.
REQ-039 Masking: pending=0010 with IrqEnable=0000 for 10 cycles -> Exc stays 0 and pending=0010; set IrqEnable=0010 -> Exc=1 with EStatus=0011 after one edge.
REQ-040 Double fault: while in HANDLER, NotAnInstr=1 -> Exc=1 with EStatus=1111 that persists through ExcAck and ERet; reset=1 -> Exc=0, EStatus=0000.
REQ-041 Collision: in the REQ cycle for IRQ0, assert ExcAck together with a new ExtIRQ[0] edge -> pending[0]=1 after the edge; Exc=1 with EStatus=0010 one cycle after ERet is followed by IDLE.
REQ-042 Reset mid-REQ with ExtIRQ held high -> Exc=0 and pending=0000 after reset, with no delivery while ExtIRQ stays high.
